rpsc_card10_input_filter: RTL

Upstream conditioning stage for RPSC card 10. Accepts the eight raw, asynchronous trip inputs destined for flip-flops FF25–FF32, synchronises and debounces them, and produces clean levels that drive the card's FF inputs (i4_FF25_IN … i76_FF32_IN). Each channel is monitored for chatter, meaning too many transitions within a time window. A chattering channel is forced to the tripped (1) state until an operator clear.

---
 rtl/rpsc_card10_input_filter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rpsc_card10_input_filter.sv
// RPSC card 10 trip-input conditioning: per-channel 2-flop synchroniser, debounce
// filter and chatter monitor feeding the FF25..FF32 inputs.
module rpsc_card10_input_filter #(
  parameter int N_CH          = 8,
  parameter int DEBOUNCE      = 16,
  parameter int CHATTER_LIMIT = 4,
  parameter int WINDOW        = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  input  logic            fault_clr,
  output logic [N_CH-1:0] ff_in,
  output logic [N_CH-1:0] trip_rise,
  output logic [N_CH-1:0] chatter_fault,
  output logic            any_fault
);

  localparam int CNT_W  = $clog2(DEBOUNCE);
  localparam int CHAT_W = $clog2(CHATTER_LIMIT + 1);
  localparam int WIN_W  = $clog2(WINDOW);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CHAT_W-1:0] CHAT_MAX = CHAT_W'(CHATTER_LIMIT);
  localparam logic [CHAT_W-1:0] CHAT_PRE = CHAT_W'(CHATTER_LIMIT - 1);
  localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CHAT_W-1:0] CHAT_ONE = CHAT_W'(1);
  localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1);

  logic [N_CH-1:0]   s1_q, s1_d;
  logic [N_CH-1:0]   s2_q, s2_d;
  logic [N_CH-1:0]   filt_q, filt_d;
  logic [CNT_W-1:0]  cnt_q  [N_CH];
  logic [CNT_W-1:0]  cnt_d  [N_CH];
  logic [CHAT_W-1:0] chat_q [N_CH];
  logic [CHAT_W-1:0] chat_d [N_CH];
  logic [N_CH-1:0]   fault_q, fault_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [N_CH-1:0]   ff_in_q, ff_in_d;
  logic [N_CH-1:0]   trip_rise_q, trip_rise_d;
  logic              any_fault_q, any_fault_d;

  logic              win_wrap_s;
  logic [N_CH-1:0]   trans_s;
  logic [N_CH-1:0]   fault_set_s;

  // Next-state logic: synchroniser, window counter, debounce, chatter and outputs.
  always_comb begin
    s1_d        = raw_in;
    s2_d        = s1_q;
    win_wrap_s  = (win_q == WIN_MAX);
    // s1_q is the value s2 takes on this edge, so this flags a transition as it lands on s2.
    trans_s     = s1_q ^ s2_q;
    filt_d      = filt_q;
    fault_set_s = '0;

    if (win_wrap_s) begin
      win_d = '0;
    end else begin
      win_d = win_q + WIN_ONE;
    end

    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      chat_d[i] = chat_q[i];

      if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end

      // A transition on the wrap edge is dropped; a fault set beats a same-edge clear.
      if (!win_wrap_s && trans_s[i] && (chat_q[i] == CHAT_PRE)) begin
        fault_set_s[i] = 1'b1;
      end else begin
        fault_set_s[i] = 1'b0;
      end

      if (win_wrap_s || fault_clr) begin
        chat_d[i] = '0;
      end else if (trans_s[i] && (chat_q[i] != CHAT_MAX)) begin
        chat_d[i] = chat_q[i] + CHAT_ONE;
      end else begin
        chat_d[i] = chat_q[i];
      end
    end

    fault_d     = fault_set_s | (fault_q & ~{N_CH{fault_clr}});
    ff_in_d     = filt_d | fault_d;
    trip_rise_d = ff_in_d & ~ff_in_q;
    any_fault_d = |fault_d;
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      filt_q      <= '0;
      fault_q     <= '0;
      win_q       <= '0;
      ff_in_q     <= '0;
      trip_rise_q <= '0;
      any_fault_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        chat_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      filt_q      <= filt_d;
      fault_q     <= fault_d;
      win_q       <= win_d;
      ff_in_q     <= ff_in_d;
      trip_rise_q <= trip_rise_d;
      any_fault_q <= any_fault_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        chat_q[i] <= chat_d[i];
      end
    end
  end

  assign ff_in         = ff_in_q;
  assign trip_rise     = trip_rise_q;
  assign chatter_fault = fault_q;
  assign any_fault     = any_fault_q;

endmodule
